se_qubip_arbiter: RTL and testbench

SE_QUBIP_ARBITER -- requirements
Module: se_qubip_arbiter

---
 rtl/se_qubip_pkg.sv | 23 ++
 rtl/se_qubip_wdog.sv | 28 ++
 rtl/se_qubip_arbiter.sv | 144 ++++++++++++++
 tb/tb_se_qubip_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/se_qubip_pkg.sv
// Shared types and constants for the two-port secure-element arbiter.
package se_qubip_pkg;

  localparam int unsigned DATA_W          = 64;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 65535;

  localparam logic [31:0] ADDR_SHA2 = 32'h0000_0020;
  localparam logic [31:0] ADDR_SHA3 = 32'h0000_0030;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  // Module-select field of a control word.
  function automatic logic [31:0] ctrl_module_addr(input logic [DATA_W-1:0] ctrl);
    return ctrl[63:32];
  endfunction

endpackage

// File: rtl/se_qubip_wdog.sv
// Owner watchdog: counts granted cycles and flags the last allowed one.
module se_qubip_wdog
  import se_qubip_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = i_enable && (r_count == LAST_CNT);

endmodule

// File: rtl/se_qubip_arbiter.sv
// Round-robin arbiter giving two requesters exclusive, time-bounded use of one secure element.
module se_qubip_arbiter
  import se_qubip_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_0,
  input  logic              i_req_1,
  input  logic [DATA_W-1:0] i_data_in_0,
  input  logic [DATA_W-1:0] i_data_in_1,
  input  logic [DATA_W-1:0] i_add_0,
  input  logic [DATA_W-1:0] i_add_1,
  input  logic [DATA_W-1:0] i_control_0,
  input  logic [DATA_W-1:0] i_control_1,
  output logic              o_gnt_0,
  output logic              o_gnt_1,
  output logic [DATA_W-1:0] o_data_out_0,
  output logic [DATA_W-1:0] o_data_out_1,
  output logic              o_end_op_0,
  output logic              o_end_op_1,
  output logic              o_timeout,
  output logic [DATA_W-1:0] o_se_data_in,
  output logic [DATA_W-1:0] o_se_add,
  output logic [DATA_W-1:0] o_se_control,
  input  logic [DATA_W-1:0] i_se_data_out,
  input  logic              i_se_end_op
);

  arb_state_t r_state, w_next_state;
  logic       r_ptr;
  logic [1:0] r_blocked;
  logic       r_timeout;

  logic       w_ok_0, w_ok_1;
  logic       w_wd_clear, w_wd_enable, w_expire;
  logic [1:0] w_to_hit;

  assign w_ok_0 = i_req_0 && !r_blocked[0];
  assign w_ok_1 = i_req_1 && !r_blocked[1];

  se_qubip_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expire (w_expire)
  );

  // Next-state logic; a release on the expiry cycle counts as voluntary.
  always_comb begin
    w_next_state = r_state;
    w_wd_clear   = 1'b0;
    w_wd_enable  = 1'b0;
    w_to_hit     = 2'b00;
    case (r_state)
      ST_IDLE: begin
        w_wd_clear = 1'b1;
        if (!r_ptr) begin
          if (w_ok_0)      w_next_state = ST_GNT0;
          else if (w_ok_1) w_next_state = ST_GNT1;
        end else begin
          if (w_ok_1)      w_next_state = ST_GNT1;
          else if (w_ok_0) w_next_state = ST_GNT0;
        end
      end
      ST_GNT0: begin
        w_wd_enable = 1'b1;
        if (!i_req_0) begin
          w_next_state = ST_GAP;
        end else if (w_expire) begin
          w_next_state = ST_GAP;
          w_to_hit[0]  = 1'b1;
        end
      end
      ST_GNT1: begin
        w_wd_enable = 1'b1;
        if (!i_req_1) begin
          w_next_state = ST_GAP;
        end else if (w_expire) begin
          w_next_state = ST_GAP;
          w_to_hit[1]  = 1'b1;
        end
      end
      ST_GAP:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 1'b0;
      r_blocked <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_timeout <= |w_to_hit;
      if (r_state == ST_IDLE && w_next_state == ST_GNT0) r_ptr <= 1'b1;
      if (r_state == ST_IDLE && w_next_state == ST_GNT1) r_ptr <= 1'b0;
      // Blocking lifts only once the requester has actually let go.
      if (w_to_hit[0])  r_blocked[0] <= 1'b1;
      else if (!i_req_0) r_blocked[0] <= 1'b0;
      if (w_to_hit[1])  r_blocked[1] <= 1'b1;
      else if (!i_req_1) r_blocked[1] <= 1'b0;
    end
  end

  assign o_gnt_0   = (r_state == ST_GNT0);
  assign o_gnt_1   = (r_state == ST_GNT1);
  assign o_timeout = r_timeout;

  // Owner-only routing; everything idles at zero so no module is selected.
  always_comb begin
    o_se_data_in = '0;
    o_se_add     = '0;
    o_se_control = '0;
    o_data_out_0 = '0;
    o_data_out_1 = '0;
    o_end_op_0   = 1'b0;
    o_end_op_1   = 1'b0;
    case (r_state)
      ST_GNT0: begin
        o_se_data_in = i_data_in_0;
        o_se_add     = i_add_0;
        o_se_control = i_control_0;
        o_data_out_0 = i_se_data_out;
        o_end_op_0   = i_se_end_op;
      end
      ST_GNT1: begin
        o_se_data_in = i_data_in_1;
        o_se_add     = i_add_1;
        o_se_control = i_control_1;
        o_data_out_1 = i_se_data_out;
        o_end_op_1   = i_se_end_op;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_se_qubip_arbiter.sv
// Directed bench for se_qubip_arbiter with a 4-cycle ownership limit.
module tb_se_qubip_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1;
  logic [63:0] data_in_0, data_in_1, add_0, add_1, control_0, control_1;
  logic        gnt_0, gnt_1;
  logic [63:0] data_out_0, data_out_1;
  logic        end_op_0, end_op_1, timeout;
  logic [63:0] se_data_in, se_add, se_control;
  logic [63:0] se_data_out;
  logic        se_end_op;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_overlap = 0;

  localparam logic [63:0] C0 = 64'h0000_0030_0000_0001;
  localparam logic [63:0] C1 = 64'h0000_0020_0000_0005;
  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] A0 = 64'h0000_0000_0000_00A0;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_00A1;
  localparam logic [63:0] SD = 64'hDEAD_BEEF_CAFE_F00D;

  se_qubip_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_0       (req_0),
    .i_req_1       (req_1),
    .i_data_in_0   (data_in_0),
    .i_data_in_1   (data_in_1),
    .i_add_0       (add_0),
    .i_add_1       (add_1),
    .i_control_0   (control_0),
    .i_control_1   (control_1),
    .o_gnt_0       (gnt_0),
    .o_gnt_1       (gnt_1),
    .o_data_out_0  (data_out_0),
    .o_data_out_1  (data_out_1),
    .o_end_op_0    (end_op_0),
    .o_end_op_1    (end_op_1),
    .o_timeout     (timeout),
    .o_se_data_in  (se_data_in),
    .o_se_add      (se_add),
    .o_se_control  (se_control),
    .i_se_data_out (se_data_out),
    .i_se_end_op   (se_end_op)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (gnt_0 && gnt_1) n_overlap++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0;
    data_in_0 = D0; data_in_1 = D1;
    add_0 = A0; add_1 = A1;
    control_0 = C0; control_1 = C1;
    se_data_out = SD; se_end_op = 1'b1;
    step(); step();

    // Reset state: idle with everything at zero.
    check_eq("rst_gnt0", 64'(gnt_0), 64'd0);
    check_eq("rst_gnt1", 64'(gnt_1), 64'd0);
    check_eq("rst_timeout", 64'(timeout), 64'd0);
    check_eq("rst_se_control", se_control, 64'd0);
    check_eq("rst_se_data_in", se_data_in, 64'd0);
    check_eq("rst_data_out_0", data_out_0, 64'd0);
    check_eq("rst_end_op_0", 64'(end_op_0), 64'd0);
    rst = 1'b0;

    // Scenario 1: single requester.
    req_0 = 1'b1;
    check_eq("s1_pre_gnt0", 64'(gnt_0), 64'd0);
    step();
    check_eq("s1_gnt0", 64'(gnt_0), 64'd1);
    check_eq("s1_gnt1", 64'(gnt_1), 64'd0);
    check_eq("s1_se_control", se_control, C0);
    check_eq("s1_se_data_in", se_data_in, D0);
    check_eq("s1_se_add", se_add, A0);
    check_eq("s1_data_out_0", data_out_0, SD);
    check_eq("s1_data_out_1", data_out_1, 64'd0);
    check_eq("s1_end_op_0", 64'(end_op_0), 64'd1);
    check_eq("s1_end_op_1", 64'(end_op_1), 64'd0);
    req_0 = 1'b0;
    step();
    check_eq("s1_gap_gnt0", 64'(gnt_0), 64'd0);
    check_eq("s1_gap_se_control", se_control, 64'd0);
    check_eq("s1_gap_end_op_0", 64'(end_op_0), 64'd0);
    check_eq("s1_gap_timeout", 64'(timeout), 64'd0);

    // Scenario 2: simultaneous requests from a fresh reset.
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    step();
    check_eq("s2_first_gnt0", 64'(gnt_0), 64'd1);
    check_eq("s2_first_gnt1", 64'(gnt_1), 64'd0);
    check_eq("s2_first_ctrl", se_control, C0);
    step();
    check_eq("s2_hold_gnt0", 64'(gnt_0), 64'd1);
    req_0 = 1'b0;
    step();
    check_eq("s2_gap_gnt0", 64'(gnt_0), 64'd0);
    check_eq("s2_gap_gnt1", 64'(gnt_1), 64'd0);
    check_eq("s2_gap_ctrl", se_control, 64'd0);
    step();
    check_eq("s2_idle_gnt1", 64'(gnt_1), 64'd0);
    check_eq("s2_idle_ctrl", se_control, 64'd0);
    step();
    check_eq("s2_second_gnt1", 64'(gnt_1), 64'd1);
    check_eq("s2_second_ctrl", se_control, C1);
    check_eq("s2_second_data_in", se_data_in, D1);
    check_eq("s2_data_out_1", data_out_1, SD);
    check_eq("s2_data_out_0", data_out_0, 64'd0);
    check_eq("s2_end_op_0", 64'(end_op_0), 64'd0);
    check_eq("s2_end_op_1", 64'(end_op_1), 64'd1);

    // Scenario 3: requester 1 holds past the limit.
    do_reset();
    req_0 = 1'b0; req_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("s3_gnt1_c%0d", i), 64'(gnt_1), 64'd1);
      check_eq($sformatf("s3_to_c%0d", i), 64'(timeout), 64'd0);
    end
    step();
    check_eq("s3_gap_gnt1", 64'(gnt_1), 64'd0);
    check_eq("s3_gap_timeout", 64'(timeout), 64'd1);
    check_eq("s3_gap_ctrl", se_control, 64'd0);
    step();
    check_eq("s3_idle_timeout", 64'(timeout), 64'd0);
    check_eq("s3_idle_gnt1", 64'(gnt_1), 64'd0);
    step();
    check_eq("s3_blocked_gnt1", 64'(gnt_1), 64'd0);
    req_1 = 1'b0;
    step();
    check_eq("s3_released_gnt1", 64'(gnt_1), 64'd0);
    req_1 = 1'b1;
    step();
    check_eq("s3_regrant_gnt1", 64'(gnt_1), 64'd1);

    // Scenario 4: reset in the middle of a grant restores the pointer.
    do_reset();
    req_0 = 1'b1; req_1 = 1'b0;
    step();
    check_eq("s4_gnt0", 64'(gnt_0), 64'd1);
    rst = 1'b1;
    step();
    check_eq("s4_rst_gnt0", 64'(gnt_0), 64'd0);
    check_eq("s4_rst_ctrl", se_control, 64'd0);
    rst = 1'b0;
    req_1 = 1'b1;
    step();
    check_eq("s4_ptr_gnt0", 64'(gnt_0), 64'd1);
    check_eq("s4_ptr_gnt1", 64'(gnt_1), 64'd0);

    // Scenario 5: release lands on the expiry cycle.
    do_reset();
    req_0 = 1'b1; req_1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("s5_gnt0_c%0d", i), 64'(gnt_0), 64'd1);
    end
    req_0 = 1'b0;
    step();
    check_eq("s5_gap_timeout", 64'(timeout), 64'd0);
    check_eq("s5_gap_gnt0", 64'(gnt_0), 64'd0);
    step();
    req_0 = 1'b1;
    step();
    check_eq("s5_regrant_gnt0", 64'(gnt_0), 64'd1);

    check_eq("mutex_grants", 64'(n_overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
